// File: rtl/signed_mul_pipelined.sv
// Signed full-width multiplier with start/busy/done handshake and a
// configurable number of product register stages.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; busy=0; done may pulse here for one cycle
// S_RUN  | operation in flight; stage counter runs down to terminal count
module signed_mul_pipelined #(
  parameter int AW              = 32,
  parameter int BW              = 32,
  parameter int PIPELINE_STAGES = 1,
  localparam int OUTW           = AW + BW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [AW-1:0]   a_in,
  input  logic [BW-1:0]   b_in,
  output logic            busy,
  output logic            done,
  output logic [OUTW-1:0] p_out
);

  localparam int STG = (PIPELINE_STAGES < 1) ? 1 : PIPELINE_STAGES;
  localparam int CW  = $clog2(STG + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_dec;
  logic            done_q, done_d;
  logic            accept, finish;
  logic [AW-1:0]   a_q;
  logic [BW-1:0]   b_q;
  logic [OUTW-1:0] a_ext, b_ext, prod, p_src, p_q;

  // Operands are sign-extended to the full product width, so the low OUTW
  // bits of an unsigned multiply are the exact two's-complement product.
  assign a_ext = {{BW{a_q[AW-1]}}, a_q};
  assign b_ext = {{AW{b_q[BW-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  // State, stage counter and done flag registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state: load counter on accept, finish when it hits terminal count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    finish  = 1'b0;
    cnt_dec = cnt_q - CW'(1);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          cnt_d   = CW'(STG);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_dec == '0) begin
          finish  = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are straight decodes of registers only
  always_comb begin
    busy  = (state_q == S_RUN);
    done  = done_q;
    p_out = p_q;
  end

  // Operand capture on the accepting edge
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= a_in;
      b_q <= b_in;
    end
  end

  // STG-1 intermediate product registers sit between the operand registers
  // and p_out, giving STG edges from accept to result; retiming can spread
  // the multiplier across them.
  if (STG == 1) begin : g_direct
    assign p_src = prod;
  end else begin : g_pipe
    logic [OUTW-1:0] pipe_q [STG-1];

    // Free-running product shift chain
    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        for (int k = 0; k < STG - 1; k++) pipe_q[k] <= '0;
      end else begin
        pipe_q[0] <= prod;
        for (int k = 1; k < STG - 1; k++) pipe_q[k] <= pipe_q[k-1];
      end
    end

    assign p_src = pipe_q[STG-2];
  end

  // Result register: updates only on the edge that raises done
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      p_q <= '0;
    end else if (finish) begin
      p_q <= p_src;
    end
  end

endmodule

// File: tb/tb_signed_mul_pipelined.sv
module tb_signed_mul_pipelined;

  localparam int N = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] start_v;
  logic [31:0]  a_v [N];
  logic [31:0]  b_v [N];
  wire  [N-1:0] busy_w;
  wire  [N-1:0] done_w;
  wire  [63:0]  p_w [N];

  int n_vec;
  int n_bad;

  signed_mul_pipelined #(.AW(32), .BW(32), .PIPELINE_STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst), .start(start_v[0]), .a_in(a_v[0]), .b_in(b_v[0]),
    .busy(busy_w[0]), .done(done_w[0]), .p_out(p_w[0]));

  signed_mul_pipelined #(.AW(32), .BW(32), .PIPELINE_STAGES(3)) u_s3 (
    .clk(clk), .rst_n(rst), .start(start_v[1]), .a_in(a_v[1]), .b_in(b_v[1]),
    .busy(busy_w[1]), .done(done_w[1]), .p_out(p_w[1]));

  signed_mul_pipelined #(.AW(32), .BW(32), .PIPELINE_STAGES(8)) u_s8 (
    .clk(clk), .rst_n(rst), .start(start_v[2]), .a_in(a_v[2]), .b_in(b_v[2]),
    .busy(busy_w[2]), .done(done_w[2]), .p_out(p_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int stg(input int idx);
    case (idx)
      0:       return 1;
      1:       return 3;
      default: return 8;
    endcase
  endfunction

  // Reference: exact signed product in 64-bit arithmetic
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint r;
    r = longint'($signed(a)) * longint'($signed(b));
    return r;
  endfunction

  // Issue one operation and report what was observed (no checking here)
  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [63:0] p,
                       output bit busy_ok, output bit overlap);
    bit got;
    @(negedge clk);
    start_v[idx] = 1'b1;
    a_v[idx] = a;
    b_v[idx] = b;
    @(posedge clk);
    lat = 0; got = 0; busy_ok = 1; overlap = 0; p = '0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      start_v[idx] = 1'b0;
      a_v[idx] = $urandom;
      b_v[idx] = $urandom;
      if (busy_w[idx] && done_w[idx]) overlap = 1;
      if (done_w[idx]) begin
        got = 1;
        p = p_w[idx];
      end else if (!busy_w[idx]) begin
        busy_ok = 0;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if ({busy_w[i], done_w[i], p_w[i]} !== 66'd0) begin
        n_bad++;
        $display("FAIL reset_hold dut%0d: busy=%b done=%b p=%h want all 0", i, busy_w[i], done_w[i], p_w[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if ({busy_w[i], done_w[i], p_w[i]} !== 66'd0) begin
        n_bad++;
        $display("FAIL reset_release dut%0d: busy=%b done=%b p=%h want all 0", i, busy_w[i], done_w[i], p_w[i]);
      end
    end
  endtask

  task automatic test_zero(input int idx);
    int lat; logic [63:0] p; bit bok, ov;
    do_op(idx, 32'd0, 32'd0, lat, p, bok, ov);
    n_vec++;
    if (lat !== stg(idx) + 1 || p !== 64'd0 || !bok || ov) begin
      n_bad++;
      $display("FAIL zero dut%0d: lat=%0d p=%h busy_ok=%0d overlap=%0d want lat=%0d p=0 busy_ok=1 overlap=0",
               idx, lat, p, bok, ov, stg(idx) + 1);
    end
  endtask

  task automatic test_corners(input int idx);
    int ta [10] = '{1, -1, 123456, -123456, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h80000000, 1000, -50000};
    int tb [10] = '{1, 2, 98765, -98765, 1, 1, 2, 32'h80000000, -2000, 40000};
    int lat; logic [63:0] p, exp; bit bok, ov, hold_bad;
    for (int k = 0; k < 10; k++) begin
      exp = ref_mul(ta[k], tb[k]);
      do_op(idx, ta[k], tb[k], lat, p, bok, ov);
      n_vec++;
      if (lat !== stg(idx) + 1 || p !== exp || !bok || ov) begin
        n_bad++;
        $display("FAIL corner%0d dut%0d: lat=%0d p=%h busy_ok=%0d overlap=%0d want lat=%0d p=%h",
                 k, idx, lat, p, bok, ov, stg(idx) + 1, exp);
      end
      hold_bad = 0;
      repeat (3) begin
        @(negedge clk);
        if (p_w[idx] !== exp || done_w[idx] !== 1'b0) hold_bad = 1;
      end
      n_vec++;
      if (hold_bad) begin
        n_bad++;
        $display("FAIL hold%0d dut%0d: p=%h done=%b want p=%h done=0", k, idx, p_w[idx], done_w[idx], exp);
      end
    end
  endtask

  task automatic test_random(input int idx);
    logic [31:0] a, b;
    int lat; logic [63:0] p, exp; bit bok, ov;
    for (int k = 0; k < 15; k++) begin
      a = $urandom;
      b = $urandom;
      exp = ref_mul(a, b);
      do_op(idx, a, b, lat, p, bok, ov);
      n_vec++;
      if (lat !== stg(idx) + 1 || p !== exp || !bok || ov) begin
        n_bad++;
        $display("FAIL random%0d dut%0d: a=%h b=%h lat=%0d p=%h want lat=%0d p=%h",
                 k, idx, a, b, lat, p, stg(idx) + 1, exp);
      end
    end
  endtask

  task automatic test_back_to_back(input int idx);
    logic [31:0] a1, b1, a2, b2, a3, b3;
    logic [63:0] ea, ec, pa, pc;
    int s, dones, dk, dones2, dk2, late;
    s = stg(idx);
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom; b2 = $urandom;
    a3 = $urandom; b3 = $urandom;
    ea = ref_mul(a1, b1);
    ec = ref_mul(a3, b3);
    @(negedge clk);
    start_v[idx] = 1'b1; a_v[idx] = a1; b_v[idx] = b1;
    @(posedge clk);
    dones = 0; dk = 0; pa = '0;
    for (int k = 1; k <= s + 1; k++) begin
      @(negedge clk);
      if (done_w[idx]) begin dones++; dk = k; pa = p_w[idx]; end
      if (k == s + 1) begin
        start_v[idx] = 1'b1; a_v[idx] = a3; b_v[idx] = b3;
      end else if (k == 1) begin
        start_v[idx] = 1'b1; a_v[idx] = a2; b_v[idx] = b2;
      end else begin
        start_v[idx] = 1'b0;
      end
    end
    n_vec++;
    if (dones !== 1 || dk !== s + 1 || pa !== ea) begin
      n_bad++;
      $display("FAIL busy_drop dut%0d: dones=%0d at=%0d p=%h want dones=1 at=%0d p=%h",
               idx, dones, dk, pa, s + 1, ea);
    end
    @(posedge clk);
    dones2 = 0; dk2 = 0; pc = '0;
    for (int k = 1; k <= s + 1; k++) begin
      @(negedge clk);
      start_v[idx] = 1'b0;
      if (done_w[idx]) begin dones2++; dk2 = k; pc = p_w[idx]; end
    end
    n_vec++;
    if (dones2 !== 1 || dk2 !== s + 1 || pc !== ec) begin
      n_bad++;
      $display("FAIL done_cycle_start dut%0d: dones=%0d at=%0d p=%h want dones=1 at=%0d p=%h",
               idx, dones2, dk2, pc, s + 1, ec);
    end
    late = 0;
    repeat (s + 4) begin
      @(negedge clk);
      if (done_w[idx] || busy_w[idx]) late++;
    end
    n_vec++;
    if (late !== 0) begin
      n_bad++;
      $display("FAIL no_queue dut%0d: extra busy/done cycles=%0d want 0", idx, late);
    end
  endtask

  task automatic test_reset_abort(input int idx);
    logic [31:0] a, b;
    int lat, dones; logic [63:0] p, exp; bit bok, ov, pnz;
    a = $urandom | 32'h1;
    b = $urandom | 32'h1;
    @(negedge clk);
    start_v[idx] = 1'b1; a_v[idx] = a; b_v[idx] = b;
    @(posedge clk);
    @(negedge clk);
    start_v[idx] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({busy_w[idx], done_w[idx], p_w[idx]} !== 66'd0) begin
      n_bad++;
      $display("FAIL abort_now dut%0d: busy=%b done=%b p=%h want all 0", idx, busy_w[idx], done_w[idx], p_w[idx]);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0; pnz = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_w[idx] || busy_w[idx]) dones++;
      if (p_w[idx] !== 64'd0) pnz = 1;
    end
    n_vec++;
    if (dones !== 0 || pnz) begin
      n_bad++;
      $display("FAIL abort_after dut%0d: busy/done cycles=%0d p=%h want 0 and p=0", idx, dones, p_w[idx]);
    end
    a = $urandom;
    b = $urandom;
    exp = ref_mul(a, b);
    do_op(idx, a, b, lat, p, bok, ov);
    n_vec++;
    if (lat !== stg(idx) + 1 || p !== exp || !bok || ov) begin
      n_bad++;
      $display("FAIL post_reset dut%0d: lat=%0d p=%h want lat=%0d p=%h", idx, lat, p, stg(idx) + 1, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    start_v = '0;
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    for (int idx = 0; idx < N; idx++) begin
      test_zero(idx);
      test_corners(idx);
      test_random(idx);
      test_back_to_back(idx);
      test_reset_abort(idx);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
